// File: rtl/uart_speed_receiver_if.sv
// Result bundle of the speed-report UART receiver: byte stream plus reassembled speed records.
// The receiver drives the master side; a host-side consumer uses the slave side.
interface uart_speed_receiver_if #(
  parameter int unsigned DataSize   = 8,
  parameter int unsigned WidthSpeed = 14
);
  logic [DataSize-1:0]   rx_data;
  logic                  rx_valid;
  logic                  frame_error;
  logic [WidthSpeed-1:0] speed;
  logic                  speed_valid;
  logic                  sync_error;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_error,
    output speed,
    output speed_valid,
    output sync_error
  );

  modport slave (
    input rx_data,
    input rx_valid,
    input frame_error,
    input speed,
    input speed_valid,
    input sync_error
  );
endinterface

// File: rtl/uart_speed_receiver.sv
// Oversampling 8N1 UART receiver that reassembles two-byte speed records
// ({2'b10, speed[13:8]} then speed[7:0]) and strobes each new speed for one clock.
module uart_speed_receiver #(
  parameter int unsigned SysFreq    = 500000,
  parameter int unsigned BaudRate   = 11500,
  parameter int unsigned Sample     = 16,
  parameter int unsigned BaudDvsr   = SysFreq / (Sample * BaudRate),
  parameter int unsigned DataSize   = 8,
  parameter int unsigned WidthSpeed = 14
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  serial_data_in,
  uart_speed_receiver_if.master rx_if
);

  localparam int unsigned CntW = (BaudDvsr > 1) ? $clog2(BaudDvsr) : 1;
  localparam int unsigned SW   = $clog2(Sample);
  localparam int unsigned NW   = $clog2(DataSize + 1);
  localparam int unsigned HiW  = 6;

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} rx_state_e;
  typedef enum logic [0:0] {AsmHdr, AsmLow} asm_state_e;

  // Input synchronizer, idle-high
  logic sync1_q, sync2_q;
  logic line;

  always_ff @(posedge clk) begin
    if (reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= serial_data_in;
      sync2_q <= sync1_q;
    end
  end

  assign line = sync2_q;

  // Free-running oversample tick
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tick;

  always_comb begin
    tick  = (cnt_q == CntW'(BaudDvsr - 1));
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset_n) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // Byte receiver
  rx_state_e           rx_state_q, rx_state_d;
  logic [SW-1:0]       s_q, s_d;
  logic [NW-1:0]       n_q, n_d;
  logic [DataSize-1:0] shreg_q, shreg_d;
  logic [DataSize-1:0] rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                frame_error_q, frame_error_d;

  always_comb begin
    rx_state_d    = rx_state_q;
    s_d           = s_q;
    n_d           = n_q;
    shreg_d       = shreg_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    frame_error_d = 1'b0;
    unique case (rx_state_q)
      StIdle: begin
        if (!line) begin
          rx_state_d = StStart;
          s_d        = '0;
        end
      end
      StStart: begin
        if (tick) begin
          if (s_q == SW'(Sample / 2 - 1)) begin
            // Still low at mid start bit: a real frame, not a glitch
            if (!line) begin
              rx_state_d = StData;
              s_d        = '0;
              n_d        = '0;
            end else begin
              rx_state_d = StIdle;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      StData: begin
        if (tick) begin
          if (s_q == SW'(Sample - 1)) begin
            s_d     = '0;
            shreg_d = {line, shreg_q[DataSize-1:1]};
            n_d     = n_q + 1'b1;
            if (n_q == NW'(DataSize - 1)) rx_state_d = StStop;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      StStop: begin
        if (tick) begin
          if (s_q == SW'(Sample - 1)) begin
            if (line) begin
              rx_data_d  = shreg_q;
              rx_valid_d = 1'b1;
              rx_state_d = StIdle;
            end else begin
              frame_error_d = 1'b1;
              rx_state_d    = StBreak;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      StBreak: begin
        // A line held low must return high before another start is accepted
        if (line) rx_state_d = StIdle;
      end
      default: rx_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      rx_state_q    <= StIdle;
      s_q           <= '0;
      n_q           <= '0;
      shreg_q       <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      rx_state_q    <= rx_state_d;
      s_q           <= s_d;
      n_q           <= n_d;
      shreg_q       <= shreg_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_error_q <= frame_error_d;
    end
  end

  // Speed record assembler
  asm_state_e            asm_q, asm_d;
  logic [HiW-1:0]        hi_q, hi_d;
  logic [WidthSpeed-1:0] speed_q, speed_d;
  logic                  speed_valid_q, speed_valid_d;
  logic                  sync_error_q, sync_error_d;

  always_comb begin
    asm_d         = asm_q;
    hi_d          = hi_q;
    speed_d       = speed_q;
    speed_valid_d = 1'b0;
    sync_error_d  = 1'b0;
    unique case (asm_q)
      AsmHdr: begin
        if (rx_valid_q) begin
          if (rx_data_q[DataSize-1 -: 2] == 2'b10) begin
            hi_d  = rx_data_q[HiW-1:0];
            asm_d = AsmLow;
          end else begin
            sync_error_d = 1'b1;
          end
        end
      end
      AsmLow: begin
        if (rx_valid_q) begin
          speed_d       = WidthSpeed'({hi_q, rx_data_q});
          speed_valid_d = 1'b1;
          asm_d         = AsmHdr;
        end else if (frame_error_q) begin
          asm_d = AsmHdr;
        end
      end
      default: asm_d = AsmHdr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      asm_q         <= AsmHdr;
      hi_q          <= '0;
      speed_q       <= '0;
      speed_valid_q <= 1'b0;
      sync_error_q  <= 1'b0;
    end else begin
      asm_q         <= asm_d;
      hi_q          <= hi_d;
      speed_q       <= speed_d;
      speed_valid_q <= speed_valid_d;
      sync_error_q  <= sync_error_d;
    end
  end

  assign rx_if.rx_data     = rx_data_q;
  assign rx_if.rx_valid    = rx_valid_q;
  assign rx_if.frame_error = frame_error_q;
  assign rx_if.speed       = speed_q;
  assign rx_if.speed_valid = speed_valid_q;
  assign rx_if.sync_error  = sync_error_q;

endmodule

// File: tb/tb_uart_speed_receiver.sv
// Bench for uart_speed_receiver: directed scenarios plus random traffic, all checked every
// cycle against a tick-position model of the line and a record-level model of the assembler.
module tb_uart_speed_receiver;
  localparam int unsigned Sample   = 16;
  localparam int unsigned Dvsr     = 2;
  localparam int unsigned DataSize = 8;
  localparam int unsigned WidthSp  = 14;
  localparam int unsigned BitClk   = Sample * Dvsr;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic serial_data_in = 1'b1;

  uart_speed_receiver_if #(.DataSize(DataSize), .WidthSpeed(WidthSp)) rx_if ();

  uart_speed_receiver #(
    .SysFreq   (500000),
    .BaudRate  (11500),
    .Sample    (Sample),
    .DataSize  (DataSize),
    .WidthSpeed(WidthSp)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .serial_data_in(serial_data_in),
    .rx_if         (rx_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Behavioural model: samples fall at fixed tick offsets after the detected start edge
  logic         m_h1 = 1'b1, m_h2 = 1'b1;
  int           edge_no = 0;
  int           mode = 0;  // 0 idle, 1 framing, 2 waiting for line high
  int           ticks_seen = 0;
  logic [7:0]   m_byte = '0;
  logic         m_rx_valid = 1'b0, m_ferr = 1'b0, m_speed_valid = 1'b0, m_sync_err = 1'b0;
  logic [7:0]   m_rx_data = '0;
  logic [13:0]  m_speed = '0;
  logic         m_have_hi = 1'b0;
  logic [5:0]   m_hi = '0;

  initial begin : model
    logic line, tick, in_now;
    int   k;
    forever begin
      @(posedge clk);
      in_now = serial_data_in;
      if (reset_n) begin
        m_h1 = 1'b1; m_h2 = 1'b1; edge_no = 0; mode = 0; ticks_seen = 0; m_byte = '0;
        m_rx_valid = 1'b0; m_ferr = 1'b0; m_speed_valid = 1'b0; m_sync_err = 1'b0;
        m_rx_data = '0; m_speed = '0; m_have_hi = 1'b0; m_hi = '0;
      end else begin
        line = m_h2;
        tick = ((edge_no % Dvsr) == Dvsr - 1);
        edge_no++;
        m_h2 = m_h1;
        m_h1 = in_now;
        m_speed_valid = 1'b0;
        m_sync_err = 1'b0;
        if (m_rx_valid) begin
          if (m_have_hi) begin
            m_speed = {m_hi, m_rx_data};
            m_speed_valid = 1'b1;
            m_have_hi = 1'b0;
          end else if (m_rx_data[7:6] == 2'b10) begin
            m_hi = m_rx_data[5:0];
            m_have_hi = 1'b1;
          end else begin
            m_sync_err = 1'b1;
          end
        end else if (m_ferr) begin
          m_have_hi = 1'b0;
        end
        m_rx_valid = 1'b0;
        m_ferr = 1'b0;
        if (mode == 0) begin
          if (!line) begin
            mode = 1;
            ticks_seen = 0;
            m_byte = '0;
          end
        end else if (mode == 2) begin
          if (line) mode = 0;
        end else if (tick) begin
          ticks_seen++;
          if (ticks_seen == Sample / 2) begin
            if (line) mode = 0;
          end else if (ticks_seen > Sample / 2 && ((ticks_seen - Sample / 2) % Sample) == 0) begin
            k = (ticks_seen - Sample / 2) / Sample;
            if (k <= DataSize) begin
              m_byte[k-1] = line;
            end else if (line) begin
              m_rx_valid = 1'b1;
              m_rx_data = m_byte;
              mode = 0;
            end else begin
              m_ferr = 1'b1;
              mode = 2;
            end
          end
        end
      end
    end
  end

  // Per-cycle compare plus strobe bookkeeping for the directed checks
  int          c_rxv = 0, c_ferr = 0, c_spv = 0, c_serr = 0;
  int          rxv_cyc = 0, spv_cyc = 0;
  logic [7:0]  last_rx = '0;
  logic [13:0] last_sp = '0;

  initial begin : compare
    logic [25:0] dut_v, mod_v;
    @(posedge clk);
    forever begin
      @(negedge clk);
      dut_v = {rx_if.rx_valid, rx_if.frame_error, rx_if.speed_valid, rx_if.sync_error,
               rx_if.rx_data, rx_if.speed};
      mod_v = {m_rx_valid, m_ferr, m_speed_valid, m_sync_err, m_rx_data, m_speed};
      n_cmp++;
      if (dut_v !== mod_v) begin
        n_bad++;
        $display("FAIL cycle_check cyc=%0d dut=%h model=%h", cyc, dut_v, mod_v);
      end
      if (rx_if.rx_valid === 1'b1) begin c_rxv++; rxv_cyc = cyc; last_rx = rx_if.rx_data; end
      if (rx_if.frame_error === 1'b1) c_ferr++;
      if (rx_if.speed_valid === 1'b1) begin c_spv++; spv_cyc = cyc; last_sp = rx_if.speed; end
      if (rx_if.sync_error === 1'b1) c_serr++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    serial_data_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    hold(1'b0, BitClk);
    for (int i = 0; i < 8; i++) hold(b[i], BitClk);
    hold(stop, BitClk);
    serial_data_in = 1'b1;
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b1;
    serial_data_in = 1'b1;
    repeat (n) @(negedge clk);
    reset_n = 1'b0;
  endtask

  int b_rxv, b_ferr, b_spv, b_serr, t0;

  task automatic snap();
    b_rxv = c_rxv; b_ferr = c_ferr; b_spv = c_spv; b_serr = c_serr;
  endtask

  initial begin : stim
    logic [7:0] rb;
    int         sel;
    @(negedge clk);
    do_reset(4);
    hold(1'b1, 40);
    check("reset_rx_data", {24'd0, rx_if.rx_data}, 32'h0);
    check("reset_speed", {18'd0, rx_if.speed}, 32'h0);

    // 1: single byte and its latency from the start edge
    snap();
    t0 = cyc;
    send_byte(8'hA5, 1'b1);
    hold(1'b1, 64);
    check("t1_rx_count", c_rxv - b_rxv, 1);
    check("t1_rx_data", {24'd0, last_rx}, 32'hA5);
    check("t1_latency_window", ((rxv_cyc - t0) >= 300 && (rxv_cyc - t0) <= 312), 1);

    // 2: back-to-back record
    do_reset(3);
    hold(1'b1, 20);
    snap();
    send_byte(8'h92, 1'b1);
    send_byte(8'h34, 1'b1);
    hold(1'b1, 64);
    check("t2_rx_count", c_rxv - b_rxv, 2);
    check("t2_speed", {18'd0, last_sp}, 32'h1234);
    check("t2_speed_lag", spv_cyc - rxv_cyc, 1);

    // 3: short glitch
    snap();
    hold(1'b0, 6);
    hold(1'b1, 400);
    check("t3_no_strobes", (c_rxv - b_rxv) + (c_ferr - b_ferr), 0);

    // 4: bad stop, held low, then recovery
    do_reset(3);
    hold(1'b1, 20);
    snap();
    send_byte(8'h55, 1'b0);
    hold(1'b0, 100);
    hold(1'b1, 40);
    send_byte(8'hA5, 1'b1);
    hold(1'b1, 64);
    check("t4_ferr_count", c_ferr - b_ferr, 1);
    check("t4_rx_count", c_rxv - b_rxv, 1);
    check("t4_rx_data", {24'd0, last_rx}, 32'hA5);

    // 5: non-header byte, then a record
    do_reset(3);
    hold(1'b1, 20);
    snap();
    send_byte(8'h34, 1'b1);
    hold(1'b1, 40);
    check("t5_sync_err", c_serr - b_serr, 1);
    send_byte(8'h80, 1'b1);
    send_byte(8'hFF, 1'b1);
    hold(1'b1, 64);
    check("t5_speed", {18'd0, last_sp}, 32'h00FF);

    // 6: reset in the middle of a data field
    do_reset(3);
    hold(1'b1, 20);
    snap();
    hold(1'b0, BitClk);
    hold(1'b0, BitClk);
    hold(1'b1, BitClk);
    hold(1'b0, 10);
    do_reset(4);
    hold(1'b1, 400);
    check("t6_aborted_silent", (c_rxv - b_rxv) + (c_ferr - b_ferr), 0);
    send_byte(8'h92, 1'b1);
    send_byte(8'h34, 1'b1);
    hold(1'b1, 64);
    check("t6_speed", {18'd0, last_sp}, 32'h1234);
    check("t6_rx_count", c_rxv - b_rxv, 2);

    // Random traffic against the model
    for (int it = 0; it < 50; it++) begin
      sel = $urandom_range(0, 9);
      rb = 8'($urandom);
      if (sel < 5) begin
        if ($urandom_range(0, 2) == 0) rb[7:6] = 2'b10;
        send_byte(rb, 1'b1);
      end else if (sel == 5) begin
        send_byte({2'b10, rb[5:0]}, 1'b1);
        send_byte(8'($urandom), 1'b1);
      end else if (sel == 6) begin
        hold(1'b0, $urandom_range(1, 12));
        hold(1'b1, 40);
      end else if (sel == 7) begin
        send_byte(rb, 1'b0);
        hold(1'b0, $urandom_range(0, 80));
        serial_data_in = 1'b1;
      end else if (sel == 8) begin
        hold(1'b0, BitClk);
        for (int i = 0; i < int'($urandom_range(0, 7)); i++) hold(rb[i], BitClk);
        hold(rb[0], $urandom_range(0, BitClk - 1));
        do_reset($urandom_range(1, 3));
        hold(1'b1, 330);
      end else begin
        send_byte(rb, 1'b1);
        do_reset($urandom_range(1, 3));
      end
      hold(1'b1, $urandom_range(0, 40));
    end
    hold(1'b1, 400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
